// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RISC-V core fetch front end.
// Holds the next-PC source select encoding and instruction length helpers.
package riscv_core_pkg;

  typedef enum logic [2:0] {
    SEL_REDIRECT = 3'd0,
    SEL_HOLD     = 3'd1,
    SEL_RAS      = 3'd2,
    SEL_BP       = 3'd3,
    SEL_SEQ      = 3'd4
  } next_pc_sel_e;

  localparam int unsigned ILEN_RVC = 2;
  localparam int unsigned ILEN_STD = 4;

  // Byte length of the instruction at the current PC.
  function automatic logic [2:0] inst_len(input logic is_compressed);
    logic [2:0] len;
    if (is_compressed) begin
      len = 3'(ILEN_RVC);
    end else begin
      len = 3'(ILEN_STD);
    end
    return len;
  endfunction

endpackage

// File: rtl/riscv_core_ras.sv
// Return-address stack: circular buffer with a top pointer and saturating count.
// When full, a push overwrites the oldest entry so the newest RAS_DEPTH returns survive.
module riscv_core_ras
  import riscv_core_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned ADDRLEN   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               replace,
  input  logic [ADDRLEN-1:0] push_addr,
  output logic [ADDRLEN-1:0] top,
  output logic               empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDRLEN-1:0] mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   ptr_nxt_s;
  logic [PTR_W-1:0]   wr_ptr_s;
  logic               wr_en_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               empty_r;

  // Pointer/count update and write-slot selection for push, replace and pop.
  always_comb begin
    ptr_nxt_s = ptr_r;
    cnt_nxt_s = cnt_r;
    wr_ptr_s  = ptr_r;
    wr_en_s   = 1'b0;
    if (push) begin
      ptr_nxt_s = ptr_r + PTR_W'(1);
      wr_ptr_s  = ptr_r + PTR_W'(1);
      wr_en_s   = 1'b1;
      if (cnt_r != CNT_W'(RAS_DEPTH)) begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (replace) begin
      wr_ptr_s = ptr_r;
      wr_en_s  = 1'b1;
    end else if (pop) begin
      if (cnt_r != CNT_W'(0)) begin
        ptr_nxt_s = ptr_r - PTR_W'(1);
        cnt_nxt_s = cnt_r - CNT_W'(1);
      end else begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Pointer, count and empty flag registers; first push lands in slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= PTR_W'(RAS_DEPTH - 1);
      cnt_r   <= CNT_W'(0);
      empty_r <= 1'b1;
    end else begin
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      empty_r <= (cnt_nxt_s == CNT_W'(0));
    end
  end

  // Entry storage, cleared on reset so the top never exposes stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem_r[i] <= {ADDRLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_s] <= push_addr;
    end
  end

  assign top   = mem_r[ptr_r];
  assign empty = empty_r;

endmodule

// File: rtl/riscv_core_pc_gen.sv
// Registered fetch PC generator: prioritised redirects, stall hold, RAS and
// branch predictor targets, then sequential RVC-aware increment.
module riscv_core_pc_gen
  import riscv_core_pkg::*;
#(
  parameter int unsigned        ADDRLEN      = 64,
  parameter logic [ADDRLEN-1:0] RESET_VECTOR = {ADDRLEN{1'b0}},
  parameter int unsigned        NUM_REDIRECT = 3,
  parameter int unsigned        RAS_DEPTH    = 8
) (
  input  logic                            i_pc_gen_clk,
  input  logic                            i_pc_gen_rst,
  input  logic                            i_pc_gen_stall,
  input  logic [NUM_REDIRECT-1:0]         i_pc_gen_redirect_valid,
  input  logic [NUM_REDIRECT*ADDRLEN-1:0] i_pc_gen_redirect_addr,
  input  logic                            i_pc_gen_bp_valid,
  input  logic                            i_pc_gen_bp_taken,
  input  logic [ADDRLEN-1:0]              i_pc_gen_bp_target,
  input  logic                            i_pc_gen_is_compressed,
  input  logic                            i_pc_gen_call,
  input  logic                            i_pc_gen_ret,
  output logic [ADDRLEN-1:0]              o_pc_gen_pc,
  output logic                            o_pc_gen_pc_valid,
  output logic                            o_pc_gen_redirected,
  output logic                            o_pc_gen_ras_empty
);

  logic [ADDRLEN-1:0] pc_r;
  logic               pc_valid_r;
  logic               redirected_r;

  logic               redir_any_s;
  logic [ADDRLEN-1:0] redir_addr_s;
  logic [ADDRLEN-1:0] seq_pc_s;
  logic [ADDRLEN-1:0] ras_top_s;
  logic               ras_empty_s;
  logic               ras_en_s;
  logic               ras_push_s;
  logic               ras_pop_s;
  logic               ras_replace_s;
  next_pc_sel_e       sel_s;
  logic [ADDRLEN-1:0] next_raw_s;
  logic [ADDRLEN-1:0] next_pc_s;

  // Fixed-priority redirect encoder: walking down means the lowest index wins.
  always_comb begin
    redir_any_s  = |i_pc_gen_redirect_valid;
    redir_addr_s = {ADDRLEN{1'b0}};
    for (int k = int'(NUM_REDIRECT) - 1; k >= 0; k--) begin
      if (i_pc_gen_redirect_valid[k]) begin
        redir_addr_s = i_pc_gen_redirect_addr[k*ADDRLEN +: ADDRLEN];
      end else begin
        redir_addr_s = redir_addr_s;
      end
    end
  end

  assign seq_pc_s = pc_r + {{(ADDRLEN-3){1'b0}}, inst_len(i_pc_gen_is_compressed)};

  // The RAS only moves on a real fetch advance; call+ret on a non-empty
  // stack swaps the top in place so the count is unchanged.
  assign ras_en_s      = !redir_any_s && !i_pc_gen_stall;
  assign ras_replace_s = ras_en_s && i_pc_gen_call && i_pc_gen_ret && !ras_empty_s;
  assign ras_push_s    = ras_en_s && i_pc_gen_call && !ras_replace_s;
  assign ras_pop_s     = ras_en_s && i_pc_gen_ret && !i_pc_gen_call && !ras_empty_s;

  riscv_core_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDRLEN   (ADDRLEN)
  ) u_ras (
    .clk       (i_pc_gen_clk),
    .rst       (i_pc_gen_rst),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .replace   (ras_replace_s),
    .push_addr (seq_pc_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );

  // Next-PC source priority.
  always_comb begin
    sel_s = SEL_SEQ;
    if (redir_any_s) begin
      sel_s = SEL_REDIRECT;
    end else if (i_pc_gen_stall) begin
      sel_s = SEL_HOLD;
    end else if (i_pc_gen_ret && !ras_empty_s) begin
      sel_s = SEL_RAS;
    end else if (i_pc_gen_bp_valid && i_pc_gen_bp_taken) begin
      sel_s = SEL_BP;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC mux; bit 0 is always cleared since no legal fetch PC is odd.
  always_comb begin
    next_raw_s = seq_pc_s;
    case (sel_s)
      SEL_REDIRECT: next_raw_s = redir_addr_s;
      SEL_HOLD:     next_raw_s = pc_r;
      SEL_RAS:      next_raw_s = ras_top_s;
      SEL_BP:       next_raw_s = i_pc_gen_bp_target;
      SEL_SEQ:      next_raw_s = seq_pc_s;
      default:      next_raw_s = seq_pc_s;
    endcase
    next_pc_s = next_raw_s & ~{{(ADDRLEN-1){1'b0}}, 1'b1};
  end

  // PC, valid and redirected registers.
  always_ff @(posedge i_pc_gen_clk) begin
    if (i_pc_gen_rst) begin
      pc_r         <= RESET_VECTOR;
      pc_valid_r   <= 1'b0;
      redirected_r <= 1'b0;
    end else begin
      pc_r         <= next_pc_s;
      pc_valid_r   <= 1'b1;
      redirected_r <= redir_any_s;
    end
  end

  assign o_pc_gen_pc         = pc_r;
  assign o_pc_gen_pc_valid   = pc_valid_r;
  assign o_pc_gen_redirected = redirected_r;
  assign o_pc_gen_ras_empty  = ras_empty_s;

endmodule

// File: tb/tb_riscv_core_pc_gen.sv
// Self-checking bench for riscv_core_pc_gen: expectations are queued as stimulus
// is driven and compared against the outputs captured after each clock edge.
module tb_riscv_core_pc_gen;

  localparam int unsigned ADDRLEN      = 64;
  localparam int unsigned NUM_REDIRECT = 3;
  localparam int unsigned RAS_DEPTH    = 8;
  localparam logic [63:0] RV           = 64'h1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic [2:0]   rv;
  logic [191:0] raddr;
  logic         bp_valid;
  logic         bp_taken;
  logic [63:0]  bp_target;
  logic         is_c;
  logic         call;
  logic         ret;
  logic [63:0]  pc;
  logic         pc_valid;
  logic         redir;
  logic         empty;

  int checks = 0;
  int errors = 0;

  logic [66:0] exp_q[$];
  logic [66:0] obs_q[$];

  riscv_core_pc_gen #(
    .ADDRLEN      (ADDRLEN),
    .RESET_VECTOR (RV),
    .NUM_REDIRECT (NUM_REDIRECT),
    .RAS_DEPTH    (RAS_DEPTH)
  ) dut (
    .i_pc_gen_clk            (clk),
    .i_pc_gen_rst            (rst),
    .i_pc_gen_stall          (stall),
    .i_pc_gen_redirect_valid (rv),
    .i_pc_gen_redirect_addr  (raddr),
    .i_pc_gen_bp_valid       (bp_valid),
    .i_pc_gen_bp_taken       (bp_taken),
    .i_pc_gen_bp_target      (bp_target),
    .i_pc_gen_is_compressed  (is_c),
    .i_pc_gen_call           (call),
    .i_pc_gen_ret            (ret),
    .o_pc_gen_pc             (pc),
    .o_pc_gen_pc_valid       (pc_valid),
    .o_pc_gen_redirected     (redir),
    .o_pc_gen_ras_empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic clr();
    rst = 1'b0; stall = 1'b0; rv = 3'b000; raddr = '0;
    bp_valid = 1'b0; bp_taken = 1'b0; bp_target = 64'h0;
    is_c = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic set_redir(input int k, input logic [63:0] a);
    rv[k] = 1'b1;
    raddr[k*64 +: 64] = a;
  endtask

  task automatic take_bp(input logic [63:0] t);
    bp_valid = 1'b1; bp_taken = 1'b1; bp_target = t;
  endtask

  task automatic expect_out(input logic [63:0] p, input logic v, input logic r, input logic e);
    exp_q.push_back({p, v, r, e});
  endtask

  // One clock edge, then capture the registered outputs away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    obs_q.push_back({pc, pc_valid, redir, empty});
    clr();
  endtask

  task automatic test_reset();
    logic [66:0] e, o;
    int step = 0;
    clr(); rst = 1'b1;
    expect_out(64'h1000, 1'b0, 1'b0, 1'b1); tick();
    expect_out(64'h1004, 1'b1, 1'b0, 1'b1); tick();
    expect_out(64'h1008, 1'b1, 1'b0, 1'b1); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_reset step %0d: got pc=%h v=%b r=%b e=%b, expected pc=%h v=%b r=%b e=%b",
                 step, o[66:3], o[2], o[1], o[0], e[66:3], e[2], e[1], e[0]);
      end
      step++;
    end
  endtask

  task automatic test_seq_len();
    logic [66:0] e, o;
    int step = 0;
    set_redir(0, 64'h2000);
    expect_out(64'h2000, 1'b1, 1'b1, 1'b1); tick();
    is_c = 1'b1;
    expect_out(64'h2002, 1'b1, 1'b0, 1'b1); tick();
    set_redir(2, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_out(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b1); tick();
    expect_out(64'h0, 1'b1, 1'b0, 1'b1); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_seq_len step %0d: got pc=%h v=%b r=%b e=%b, expected pc=%h v=%b r=%b e=%b",
                 step, o[66:3], o[2], o[1], o[0], e[66:3], e[2], e[1], e[0]);
      end
      step++;
    end
  endtask

  task automatic test_priority();
    logic [66:0] e, o;
    int step = 0;
    set_redir(1, 64'h4000); set_redir(2, 64'h5000); stall = 1'b1;
    expect_out(64'h4000, 1'b1, 1'b1, 1'b1); tick();
    stall = 1'b1; take_bp(64'h9000);
    expect_out(64'h4000, 1'b1, 1'b0, 1'b1); tick();
    set_redir(0, 64'h6001); set_redir(1, 64'h4000); set_redir(2, 64'h5000);
    expect_out(64'h6000, 1'b1, 1'b1, 1'b1); tick();
    bp_valid = 1'b1; bp_taken = 1'b0; bp_target = 64'h9000;
    expect_out(64'h6004, 1'b1, 1'b0, 1'b1); tick();
    take_bp(64'h7003);
    expect_out(64'h7002, 1'b1, 1'b0, 1'b1); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_priority step %0d: got pc=%h v=%b r=%b e=%b, expected pc=%h v=%b r=%b e=%b",
                 step, o[66:3], o[2], o[1], o[0], e[66:3], e[2], e[1], e[0]);
      end
      step++;
    end
  endtask

  task automatic test_ras();
    logic [66:0] e, o;
    int step = 0;
    set_redir(0, 64'h3000);
    expect_out(64'h3000, 1'b1, 1'b1, 1'b1); tick();
    call = 1'b1; take_bp(64'h8000);
    expect_out(64'h8000, 1'b1, 1'b0, 1'b0); tick();
    expect_out(64'h8004, 1'b1, 1'b0, 1'b0); tick();
    ret = 1'b1;
    expect_out(64'h3004, 1'b1, 1'b0, 1'b1); tick();
    ret = 1'b1; take_bp(64'h7000);
    expect_out(64'h7000, 1'b1, 1'b0, 1'b1); tick();
    stall = 1'b1; call = 1'b1;
    expect_out(64'h7000, 1'b1, 1'b0, 1'b1); tick();
    call = 1'b1; is_c = 1'b1; take_bp(64'h9000);
    expect_out(64'h9000, 1'b1, 1'b0, 1'b0); tick();
    call = 1'b1; ret = 1'b1;
    expect_out(64'h7002, 1'b1, 1'b0, 1'b0); tick();
    set_redir(1, 64'hA000); ret = 1'b1;
    expect_out(64'hA000, 1'b1, 1'b1, 1'b0); tick();
    ret = 1'b1;
    expect_out(64'h9004, 1'b1, 1'b0, 1'b1); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_ras step %0d: got pc=%h v=%b r=%b e=%b, expected pc=%h v=%b r=%b e=%b",
                 step, o[66:3], o[2], o[1], o[0], e[66:3], e[2], e[1], e[0]);
      end
      step++;
    end
  endtask

  task automatic test_ras_overflow();
    logic [66:0] e, o;
    int step = 0;
    set_redir(0, 64'h10000);
    expect_out(64'h10000, 1'b1, 1'b1, 1'b1); tick();
    for (int i = 0; i < 9; i++) begin
      call = 1'b1; take_bp(64'h10000 + 64'((i + 1) * 'h100));
      expect_out(64'h10000 + 64'((i + 1) * 'h100), 1'b1, 1'b0, 1'b0); tick();
    end
    for (int j = 0; j < 8; j++) begin
      ret = 1'b1;
      expect_out(64'h10000 + 64'((8 - j) * 'h100) + 64'h4, 1'b1, 1'b0, (j == 7)); tick();
    end
    ret = 1'b1;
    expect_out(64'h10108, 1'b1, 1'b0, 1'b1); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_ras_overflow step %0d: got pc=%h v=%b r=%b e=%b, expected pc=%h v=%b r=%b e=%b",
                 step, o[66:3], o[2], o[1], o[0], e[66:3], e[2], e[1], e[0]);
      end
      step++;
    end
  endtask

  task automatic test_reset_mid();
    logic [66:0] e, o;
    int step = 0;
    call = 1'b1; take_bp(64'hB000);
    expect_out(64'hB000, 1'b1, 1'b0, 1'b0); tick();
    rst = 1'b1; set_redir(0, 64'hC000); stall = 1'b1;
    expect_out(64'h1000, 1'b0, 1'b0, 1'b1); tick();
    expect_out(64'h1004, 1'b1, 1'b0, 1'b1); tick();
    ret = 1'b1;
    expect_out(64'h1008, 1'b1, 1'b0, 1'b1); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL test_reset_mid step %0d: got pc=%h v=%b r=%b e=%b, expected pc=%h v=%b r=%b e=%b",
                 step, o[66:3], o[2], o[1], o[0], e[66:3], e[2], e[1], e[0]);
      end
      step++;
    end
  endtask

  initial begin
    clr();
    @(negedge clk);
    test_reset();
    test_seq_len();
    test_priority();
    test_ras();
    test_ras_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
